// File: rtl/rosc_pkg.sv
// Shared definitions for the ring-oscillator sample controller: FSM state
// encoding, noise LFSR geometry and counter widths.
package rosc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RUN    = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int               LFSR_W        = 16;
  // Feedback taps at stages 16,14,13,11 (bit indices 15,13,12,10)
  localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hACE1;

  localparam int SETTLE_CNT_W = 8;
  localparam int WINDOW_CNT_W = 16;

  // Bit counter must hold the value DATA_W itself without wrapping
  function automatic int bit_cnt_w(input int data_w);
    return $clog2(data_w) + 1;
  endfunction

endpackage

// File: rtl/rosc_sample_ctrl_if.sv
// Request/response and oscillator-control signal bundle for rosc_sample_ctrl.
// master = requester side (also models the oscillator), slave = controller.
interface rosc_sample_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              abort;
  logic [31:0]       cfg_deltax;
  logic [31:0]       cfg_deltay;
  logic [7:0]        cfg_settle;
  logic [15:0]       cfg_window;
  logic              busy;
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              data_ready;
  logic              osc_rst;
  logic              osc_enb;
  logic [31:0]       osc_deltax;
  logic [31:0]       osc_deltay;
  logic [3:0]        osc_noise;
  logic              osc_out;

  modport master (
    output start, abort, cfg_deltax, cfg_deltay, cfg_settle, cfg_window,
           data_ready, osc_out,
    input  busy, data, data_valid, osc_rst, osc_enb, osc_deltax, osc_deltay,
           osc_noise
  );

  modport slave (
    input  start, abort, cfg_deltax, cfg_deltay, cfg_settle, cfg_window,
           data_ready, osc_out,
    output busy, data, data_valid, osc_rst, osc_enb, osc_deltax, osc_deltay,
           osc_noise
  );
endinterface

// File: rtl/rosc_lfsr.sv
// 16-bit Fibonacci noise LFSR. Steps only while enabled so the jitter
// sequence is tied to oscillator run time; a nonzero seed keeps it out of
// the all-zero lock-up state.
module rosc_lfsr
  import rosc_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [3:0] noise
);

  logic [LFSR_W-1:0] state_q, state_d;

  // Next state: shift left, XOR of tapped bits enters bit 0
  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = {state_q[LFSR_W-2:0], ^(state_q & LFSR_TAPS)};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign noise = state_q[3:0];

endmodule

// File: rtl/rosc_sample_ctrl.sv
// Ring-oscillator sample controller: holds the oscillator in reset for a
// settle period, then alternates RUN windows and single SAMPLE cycles,
// shifting one oscillator bit per sample until DATA_W bits are collected.
module rosc_sample_ctrl
  import rosc_pkg::*;
#(
  parameter int               DATA_W    = 32,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  rosc_sample_ctrl_if.slave bus
);

  localparam int BCW = bit_cnt_w(DATA_W);

  state_e                  state_q, state_d;
  logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [WINDOW_CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [WINDOW_CNT_W-1:0] win_len_q, win_len_d;
  logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [31:0]             deltax_q, deltax_d;
  logic [31:0]             deltay_q, deltay_d;
  logic                    in_busy;

  assign in_busy = (state_q == ST_SETTLE) || (state_q == ST_RUN) ||
                   (state_q == ST_SAMPLE);

  // Next-state, counter and data-path logic; abort in a busy state wins
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    win_cnt_d    = win_cnt_q;
    win_len_d    = win_len_q;
    bit_cnt_d    = bit_cnt_q;
    data_d       = data_q;
    deltax_d     = deltax_q;
    deltay_d     = deltay_q;
    if (in_busy && bus.abort) begin
      state_d   = ST_IDLE;
      data_d    = '0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            deltax_d     = bus.cfg_deltax;
            deltay_d     = bus.cfg_deltay;
            settle_cnt_d = (bus.cfg_settle == '0) ? SETTLE_CNT_W'(1) : bus.cfg_settle;
            win_len_d    = (bus.cfg_window == '0) ? WINDOW_CNT_W'(1) : bus.cfg_window;
            win_cnt_d    = win_len_d;
            bit_cnt_d    = '0;
            data_d       = '0;
            state_d      = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q <= SETTLE_CNT_W'(1)) begin
            state_d = ST_RUN;
          end else begin
            settle_cnt_d = settle_cnt_q - 1'b1;
          end
        end
        ST_RUN: begin
          if (win_cnt_q <= WINDOW_CNT_W'(1)) begin
            state_d = ST_SAMPLE;
          end else begin
            win_cnt_d = win_cnt_q - 1'b1;
          end
        end
        ST_SAMPLE: begin
          data_d    = {data_q[DATA_W-2:0], bus.osc_out};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BCW'(DATA_W - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_RUN;
            win_cnt_d = win_len_q;
          end
        end
        ST_DONE: begin
          if (bus.data_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control and data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      win_len_q    <= '0;
      bit_cnt_q    <= '0;
      data_q       <= '0;
      deltax_q     <= '0;
      deltay_q     <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      win_cnt_q    <= win_cnt_d;
      win_len_q    <= win_len_d;
      bit_cnt_q    <= bit_cnt_d;
      data_q       <= data_d;
      deltax_q     <= deltax_d;
      deltay_q     <= deltay_d;
    end
  end

  // Oscillator runs only in RUN; it is held in reset everywhere except RUN/SAMPLE
  assign bus.osc_enb    = (state_q == ST_RUN);
  assign bus.osc_rst    = (state_q == ST_IDLE) || (state_q == ST_SETTLE) ||
                          (state_q == ST_DONE);
  assign bus.busy       = in_busy;
  assign bus.data_valid = (state_q == ST_DONE);
  assign bus.data       = data_q;
  assign bus.osc_deltax = deltax_q;
  assign bus.osc_deltay = deltay_q;

  rosc_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.osc_enb),
    .noise (bus.osc_noise)
  );

endmodule

// File: tb/tb_rosc_sample_ctrl.sv
// Directed bench for rosc_sample_ctrl with a bit-pattern oscillator model and
// a scoreboard of expected sample words and start-to-valid latencies.
module tb_rosc_sample_ctrl;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  int          n_cmp;
  int          n_fail;
  exp_t        sb[$];
  logic [31:0] pat;
  int          samp_n;
  logic        in_sample;

  rosc_sample_ctrl_if #(.DATA_W(32)) bif ();

  rosc_sample_ctrl #(
    .DATA_W    (32),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator model: emits pat MSB-first, one bit per SAMPLE cycle
  assign in_sample   = bif.busy && !bif.osc_rst && !bif.osc_enb;
  assign bif.osc_out = in_sample && (samp_n < 32) && pat[31 - samp_n];

  always @(posedge clk) begin
    if (rst || !bif.busy) samp_n <= 0;
    else if (in_sample)   samp_n <= samp_n + 1;
  end

  function automatic logic [15:0] lfsr_model(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic int lat_model(input int s, input int w);
    int se, we;
    se = (s == 0) ? 1 : s;
    we = (w == 0) ? 1 : w;
    return se + 32 * (we + 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},   bif.busy,       1'b0);
    chk({tag, "_orst"},   bif.osc_rst,    1'b1);
    chk({tag, "_oenb"},   bif.osc_enb,    1'b0);
    chk({tag, "_dx"},     bif.osc_deltax, 32'h0);
    chk({tag, "_dy"},     bif.osc_deltay, 32'h0);
    chk({tag, "_noise"},  bif.osc_noise,  4'h1);
    chk({tag, "_data"},   bif.data,       32'h0);
    chk({tag, "_valid"},  bif.data_valid, 1'b0);
  endtask

  // Issue an accepted start and record the expected result
  task automatic do_start(input logic [31:0] dx, input logic [31:0] dy,
                          input int s, input int w, input logic [31:0] p);
    exp_t e;
    bif.cfg_deltax = dx;
    bif.cfg_deltay = dy;
    bif.cfg_settle = 8'(s);
    bif.cfg_window = 16'(w);
    pat            = p;
    e.data         = p;
    e.lat          = lat_model(s, w);
    sb.push_back(e);
    bif.start = 1'b1;
    step();
    bif.start = 1'b0;
  endtask

  // Wait (bounded) for data_valid, then pop and compare against the scoreboard
  task automatic expect_output(input string tag, input int pre_edges);
    int   n;
    exp_t e;
    n = 0;
    while (bif.data_valid !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_valid_seen"}, bif.data_valid, 1'b1);
    chk({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_data"},    bif.data,      e.data);
      chk({tag, "_latency"}, pre_edges + n, e.lat);
    end
  endtask

  initial begin
    logic [15:0] lm;
    int          n;
    n_cmp          = 0;
    n_fail         = 0;
    pat            = 32'h0;
    rst            = 1'b1;
    bif.start      = 1'b0;
    bif.abort      = 1'b0;
    bif.cfg_deltax = 32'h0;
    bif.cfg_deltay = 32'h0;
    bif.cfg_settle = 8'd0;
    bif.cfg_window = 16'd0;
    bif.data_ready = 1'b0;
    step();
    step();
    chk_reset("por");
    rst = 1'b0;
    step();

    // Test 1: settle=2, window=3, alternating oscillator bits
    do_start(32'h1111_2222, 32'h3333_4444, 2, 3, 32'hAAAA_AAAA);
    chk("t1_settle1_orst", bif.osc_rst, 1'b1);
    chk("t1_settle1_oenb", bif.osc_enb, 1'b0);
    chk("t1_busy", bif.busy, 1'b1);
    chk("t1_dx", bif.osc_deltax, 32'h1111_2222);
    chk("t1_dy", bif.osc_deltay, 32'h3333_4444);
    step();
    chk("t1_settle2_orst", bif.osc_rst, 1'b1);
    step();
    chk("t1_run1_oenb", bif.osc_enb, 1'b1);
    chk("t1_run1_orst", bif.osc_rst, 1'b0);
    bif.start      = 1'b1;
    bif.cfg_deltax = 32'hFFFF_0000;
    step();
    chk("t1_run2_oenb", bif.osc_enb, 1'b1);
    step();
    chk("t1_run3_oenb", bif.osc_enb, 1'b1);
    step();
    chk("t1_sample_oenb", bif.osc_enb, 1'b0);
    chk("t1_sample_orst", bif.osc_rst, 1'b0);
    bif.start = 1'b0;
    expect_output("t1", 5);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t1_hold_valid", bif.data_valid, 1'b1);
      chk("t1_hold_data", bif.data, 32'hAAAA_AAAA);
    end
    chk("t1_done_orst", bif.osc_rst, 1'b1);
    bif.data_ready = 1'b1;
    step();
    bif.data_ready = 1'b0;
    chk("t1_valid_drop", bif.data_valid, 1'b0);
    chk("t1_idle_busy", bif.busy, 1'b0);
    chk("t1_idle_oenb", bif.osc_enb, 1'b0);
    chk("t1_data_kept", bif.data, 32'hAAAA_AAAA);
    chk("t1_dx_kept", bif.osc_deltax, 32'h1111_2222);

    // Test 2: settle=0, window=0, LFSR advances exactly 32 times from seed
    rst = 1'b1;
    step();
    chk_reset("t2_rst");
    rst = 1'b0;
    bif.data_ready = 1'b1;
    do_start(32'hCAFE_0001, 32'h0BAD_0002, 0, 0, 32'h1234_5678);
    chk("t2_settle_orst", bif.osc_rst, 1'b1);
    step();
    chk("t2_run_oenb", bif.osc_enb, 1'b1);
    step();
    chk("t2_sample_oenb", bif.osc_enb, 1'b0);
    expect_output("t2", 2);
    lm = 16'hACE1;
    for (int i = 0; i < 32; i++) lm = lfsr_model(lm);
    chk("t2_noise", bif.osc_noise, lm[3:0]);
    step();
    chk("t2_valid_drop", bif.data_valid, 1'b0);
    bif.data_ready = 1'b0;

    // Test 3: abort during the 10th RUN burst, then start+abort in IDLE
    do_start(32'h5555_0000, 32'h0000_5555, 1, 2, 32'hFFFF_FFFF);
    void'(sb.pop_back());
    for (int i = 0; i < 28; i++) step();
    chk("t3_in_run", bif.osc_enb, 1'b1);
    bif.abort = 1'b1;
    step();
    bif.abort = 1'b0;
    chk("t3_busy", bif.busy, 1'b0);
    chk("t3_data_cleared", bif.data, 32'h0);
    chk("t3_valid", bif.data_valid, 1'b0);
    chk("t3_orst", bif.osc_rst, 1'b1);
    n = 0;
    while (bif.data_valid !== 1'b1 && n < 150) begin
      step();
      n++;
    end
    chk("t3_no_valid", n, 150);
    bif.start = 1'b1;
    bif.abort = 1'b1;
    step();
    bif.start = 1'b0;
    bif.abort = 1'b0;
    chk("t3_sa_busy", bif.busy, 1'b0);
    step();
    chk("t3_sa_busy2", bif.busy, 1'b0);

    // Test 4: reset mid-RUN, then reset while in DONE
    do_start(32'hDEAD_BEEF, 32'hFEED_F00D, 3, 5, 32'h0F0F_A5C3);
    void'(sb.pop_back());
    for (int i = 0; i < 6; i++) step();
    chk("t4_in_run", bif.osc_enb, 1'b1);
    rst = 1'b1;
    step();
    chk_reset("t4_rst_run");
    rst = 1'b0;
    do_start(32'h0123_4567, 32'h89AB_CDEF, 0, 0, 32'h0F0F_A5C3);
    expect_output("t4", 0);
    bif.start      = 1'b1;
    bif.cfg_deltax = 32'h7777_7777;
    step();
    bif.start = 1'b0;
    chk("t4_done_valid", bif.data_valid, 1'b1);
    chk("t4_done_data", bif.data, 32'h0F0F_A5C3);
    chk("t4_done_dx", bif.osc_deltax, 32'h0123_4567);
    rst = 1'b1;
    step();
    chk_reset("t4_rst_done");
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
